// File: rtl/sched_pkg.sv
// Shared types and defaults for the process scheduler and its slot picker.
package sched_pkg;

  typedef enum logic [1:0] {
    S_OS     = 2'd0,
    S_SELECT = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  localparam int NPROG_DEF     = 8;
  localparam int PROG_SIZE_DEF = 200;
  localparam int QW_DEF        = 32;
  localparam int SLOT_W        = $clog2(NPROG_DEF);

endpackage

// File: rtl/rr_picker.sv
// Combinational next-slot picker over the ready set; slot 0 (OS) is never chosen.
// SCHED_RR_EN selects round-robin search from start; otherwise lowest ready slot wins.
module rr_picker
  import sched_pkg::*;
#(
  parameter int NPROG = NPROG_DEF,
  parameter int IDW   = $clog2(NPROG)
) (
  input  logic [NPROG-1:0] ready_mask,
`ifdef SCHED_RR_EN
  input  logic [IDW-1:0]   start,
`endif
  output logic             found,
  output logic [IDW-1:0]   id
);

  logic [NPROG-1:0] user_mask;

  assign user_mask = ready_mask & ~{{(NPROG-1){1'b0}}, 1'b1};

`ifdef SCHED_RR_EN
  logic [IDW:0]   cand;
  logic [IDW-1:0] slot;

  // Walk slots start..NPROG-1 then 1..start-1, keeping the first hit.
  always_comb begin
    found = 1'b0;
    id    = '0;
    cand  = '0;
    slot  = '0;
    for (int k = 0; k < NPROG-1; k++) begin
      cand = {1'b0, start} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NPROG))
        cand = cand - (IDW+1)'(NPROG-1);
      slot = cand[IDW-1:0];
      if (!found && user_mask[slot]) begin
        found = 1'b1;
        id    = slot;
      end
    end
  end
`else
  // Scan downward so the lowest-numbered ready slot is written last.
  always_comb begin
    found = 1'b0;
    id    = '0;
    for (int k = NPROG-1; k >= 0; k--) begin
      if (user_mask[k]) begin
        found = 1'b1;
        id    = IDW'(k);
      end
    end
  end
`endif

endmodule

// File: rtl/process_scheduler.sv
// Time-slice scheduler: tracks ready slots, counts retirements against a quantum,
// preempts back to the OS and dispatches the next slot. SCHED_RR_EN enables round-robin.
module process_scheduler
  import sched_pkg::*;
#(
  parameter int NPROG     = NPROG_DEF,
  parameter int PROG_SIZE = PROG_SIZE_DEF,
  parameter int QW        = QW_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     stop,
  input  logic                     defquantum,
  input  logic [QW-1:0]            quantum_in,
  input  logic                     admit,
  input  logic [$clog2(NPROG)-1:0] admit_id,
  input  logic                     retire,
  input  logic                     endProgram,
  input  logic                     yield,
  output logic [$clog2(NPROG)-1:0] active,
  output logic [31:0]              base,
  output logic                     preempt,
  output logic                     dispatch,
  output logic [NPROG-1:0]         ready_mask,
  output logic                     idle
);

  localparam int IDW = $clog2(NPROG);

  state_t           state, state_n;
  logic [IDW-1:0]   active_n;
  logic [31:0]      base_n;
  logic [QW-1:0]    quantum;
  logic [QW-1:0]    count, count_n;
  logic             preempt_n, dispatch_n;
  logic [NPROG-1:0] mask_n;
  logic             end_clr;
  logic             expire;
  logic             pick_found;
  logic [IDW-1:0]   pick_id;

`ifdef SCHED_RR_EN
  logic [IDW-1:0]   last, last_n;
  logic [IDW-1:0]   start;

  assign start = (last == IDW'(NPROG-1)) ? IDW'(1) : last + IDW'(1);

  rr_picker #(.NPROG(NPROG), .IDW(IDW)) u_picker (
    .ready_mask (ready_mask),
    .start      (start),
    .found      (pick_found),
    .id         (pick_id)
  );
`else
  rr_picker #(.NPROG(NPROG), .IDW(IDW)) u_picker (
    .ready_mask (ready_mask),
    .found      (pick_found),
    .id         (pick_id)
  );
`endif

  // >= rather than == so a quantum lowered mid-slice expires on the next retire.
  assign expire = (quantum != '0) && (count >= quantum - QW'(1));
  assign idle   = (ready_mask == '0);

  always_comb begin
    state_n    = state;
    active_n   = active;
    base_n     = base;
    count_n    = count;
    preempt_n  = 1'b0;
    dispatch_n = 1'b0;
    end_clr    = 1'b0;
`ifdef SCHED_RR_EN
    last_n     = last;
`endif
    if (!stop) begin
      case (state)
        S_OS: begin
          if (yield && (ready_mask != '0))
            state_n = S_SELECT;
        end
        S_SELECT: begin
          if (pick_found) begin
            active_n   = pick_id;
            base_n     = 32'(PROG_SIZE) * 32'(pick_id);
            count_n    = '0;
            dispatch_n = 1'b1;
            state_n    = S_RUN;
          end else begin
            state_n    = S_OS;
          end
        end
        S_RUN: begin
          if (endProgram) begin
            end_clr   = 1'b1;
`ifdef SCHED_RR_EN
            last_n    = active;
`endif
            active_n  = '0;
            base_n    = '0;
            preempt_n = 1'b1;
            state_n   = S_OS;
          end else if (retire && expire) begin
`ifdef SCHED_RR_EN
            last_n    = active;
`endif
            active_n  = '0;
            base_n    = '0;
            preempt_n = 1'b1;
            state_n   = S_OS;
          end else if (retire && (count != '1)) begin
            count_n   = count + QW'(1);
          end
        end
        default: state_n = S_OS;
      endcase
    end
  end

  // Admit is applied after the endProgram clear so a same-slot admit wins.
  always_comb begin
    mask_n = ready_mask;
    if (end_clr)
      mask_n[active] = 1'b0;
    if (admit)
      mask_n[admit_id] = 1'b1;
    mask_n[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_OS;
      active     <= '0;
      base       <= '0;
      quantum    <= '0;
      count      <= '0;
      preempt    <= 1'b0;
      dispatch   <= 1'b0;
      ready_mask <= '0;
`ifdef SCHED_RR_EN
      last       <= '0;
`endif
    end else begin
      state      <= state_n;
      active     <= active_n;
      base       <= base_n;
      count      <= count_n;
      preempt    <= preempt_n;
      dispatch   <= dispatch_n;
      ready_mask <= mask_n;
      if (defquantum)
        quantum  <= quantum_in;
`ifdef SCHED_RR_EN
      last       <= last_n;
`endif
    end
  end

endmodule

// File: tb/tb_process_scheduler.sv
// Scoreboard bench for process_scheduler: stimulus queues expected dispatch/preempt
// pulses, a negedge monitor pops and compares them whenever the DUT pulses.
module tb_process_scheduler;

`ifdef SCHED_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stop = 1'b0;
  logic        defquantum = 1'b0;
  logic [31:0] quantum_in = '0;
  logic        admit = 1'b0;
  logic [2:0]  admit_id = '0;
  logic        retire = 1'b0;
  logic        endProgram = 1'b0;
  logic        yield = 1'b0;
  logic [2:0]  active;
  logic [31:0] base;
  logic        preempt;
  logic        dispatch;
  logic [7:0]  ready_mask;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          disp;
    logic [2:0]  act;
    logic [31:0] base;
    logic [7:0]  mask;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  process_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .stop       (stop),
    .defquantum (defquantum),
    .quantum_in (quantum_in),
    .admit      (admit),
    .admit_id   (admit_id),
    .retire     (retire),
    .endProgram (endProgram),
    .yield      (yield),
    .active     (active),
    .base       (base),
    .preempt    (preempt),
    .dispatch   (dispatch),
    .ready_mask (ready_mask),
    .idle       (idle)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic void exp_disp(input logic [2:0] a, input logic [7:0] m);
    sbq.push_back('{1'b1, a, 32'(a) * 32'd200, m});
  endfunction

  function automatic void exp_pre(input logic [7:0] m);
    sbq.push_back('{1'b0, 3'd0, 32'd0, m});
  endfunction

  always @(negedge clock) begin
    if (preempt || dispatch) begin
      chk("pulse_exclusive", 32'(preempt & dispatch), 32'd0);
      if (sbq.size() == 0) begin
        chk(dispatch ? "unexpected_dispatch" : "unexpected_preempt", 32'd1, 32'd0);
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_kind_is_dispatch", 32'(dispatch), 32'(mon_e.disp));
        chk("pulse_active", 32'(active), 32'(mon_e.act));
        chk("pulse_base", base, mon_e.base);
        chk("pulse_ready_mask", 32'(ready_mask), 32'(mon_e.mask));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_admit(input logic [2:0] id);
    admit = 1'b1;
    admit_id = id;
    tick();
    admit = 1'b0;
  endtask

  task automatic set_q(input logic [31:0] q);
    defquantum = 1'b1;
    quantum_in = q;
    tick();
    defquantum = 1'b0;
  endtask

  task automatic pulse_yield();
    yield = 1'b1;
    tick();
    yield = 1'b0;
  endtask

  task automatic pulse_retire();
    retire = 1'b1;
    tick();
    retire = 1'b0;
  endtask

  task automatic pulse_end();
    endProgram = 1'b1;
    tick();
    endProgram = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Cycles from the stimulus cycle to the pulse; 0 means it never came.
  task automatic wait_pulse(input bit want_disp, input int lat, input string name);
    int got = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (want_disp ? dispatch : preempt) begin
        got = k;
        break;
      end
    end
    chk(name, 32'(got), 32'(lat));
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset values, then a yield with nothing ready
    @(negedge clock);
    chk("reset_active", 32'(active), 32'd0);
    chk("reset_base", base, 32'd0);
    chk("reset_preempt", 32'(preempt), 32'd0);
    chk("reset_dispatch", 32'(dispatch), 32'd0);
    chk("reset_mask", 32'(ready_mask), 32'd0);
    chk("reset_idle", 32'(idle), 32'd1);
    tick();
    pulse_yield();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("empty_yield_idle", 32'(idle), 32'd1);
      chk("empty_yield_active", 32'(active), 32'd0);
    end
    tick();

    // Quantum 3 with slots 2 and 5
    set_q(32'd3);
    do_admit(3'd2);
    do_admit(3'd5);
    @(negedge clock);
    chk("admit_mask", 32'(ready_mask), 32'h24);
    chk("admit_idle", 32'(idle), 32'd0);
    tick();
    exp_disp(3'd2, 8'h24);
    pulse_yield();
    wait_pulse(1'b1, 2, "dispatch_latency");
    pulse_retire();
    pulse_retire();
    exp_pre(8'h24);
    pulse_retire();
    wait_pulse(1'b0, 1, "expiry_latency");
    exp_disp(RR ? 3'd5 : 3'd2, 8'h24);
    pulse_yield();
    wait_pulse(1'b1, 2, "second_dispatch_latency");
    exp_pre(RR ? 8'h04 : 8'h20);
    pulse_end();
    wait_pulse(1'b0, 1, "end_latency");
    exp_disp(RR ? 3'd2 : 3'd5, RR ? 8'h04 : 8'h20);
    pulse_yield();
    wait_pulse(1'b1, 2, "third_dispatch_latency");
    exp_pre(8'h00);
    pulse_end();
    wait_pulse(1'b0, 1, "final_end_latency");
    @(negedge clock);
    chk("drained_idle", 32'(idle), 32'd1);
    tick();

    // Quantum 0: no preemption on a long run
    set_q(32'd0);
    do_admit(3'd3);
    exp_disp(3'd3, 8'h08);
    pulse_yield();
    wait_pulse(1'b1, 2, "q0_dispatch_latency");
    retire = 1'b1;
    repeat (1000) tick();
    retire = 1'b0;
    exp_pre(8'h00);
    pulse_end();
    wait_pulse(1'b0, 1, "q0_end_latency");
    @(negedge clock);
    chk("q0_bit3_clear", 32'(ready_mask[3]), 32'd0);
    chk("q0_idle", 32'(idle), 32'd1);
    tick();

    // Quantum lowered below the running count expires on the next retire
    do_admit(3'd3);
    exp_disp(3'd3, 8'h08);
    pulse_yield();
    wait_pulse(1'b1, 2, "requant_dispatch_latency");
    retire = 1'b1;
    repeat (10) tick();
    retire = 1'b0;
    set_q(32'd4);
    exp_pre(8'h08);
    pulse_retire();
    wait_pulse(1'b0, 1, "requant_expiry_latency");
    do_reset();

    // Quantum 1 with slots 1, 2, 3: dispatch order
    set_q(32'd1);
    do_admit(3'd1);
    do_admit(3'd2);
    do_admit(3'd3);
    for (int i = 0; i < 4; i++) begin
      exp_disp(RR ? 3'((i % 3) + 1) : 3'd1, 8'h0E);
      pulse_yield();
      wait_pulse(1'b1, 2, "order_dispatch_latency");
      exp_pre(8'h0E);
      pulse_retire();
      wait_pulse(1'b0, 1, "order_expiry_latency");
    end
    do_reset();

    // Same-cycle admit and endProgram for the running slot
    do_admit(3'd4);
    exp_disp(3'd4, 8'h10);
    pulse_yield();
    wait_pulse(1'b1, 2, "admit_end_dispatch_latency");
    exp_pre(8'h10);
    admit = 1'b1;
    admit_id = 3'd4;
    endProgram = 1'b1;
    tick();
    admit = 1'b0;
    endProgram = 1'b0;
    wait_pulse(1'b0, 1, "admit_end_preempt_latency");
    @(negedge clock);
    chk("admit_wins_bit4", 32'(ready_mask[4]), 32'd1);
    tick();

    // Reset mid-slice: no preempt, reset values back
    exp_disp(3'd4, 8'h10);
    pulse_yield();
    wait_pulse(1'b1, 2, "midslice_dispatch_latency");
    pulse_retire();
    pulse_retire();
    do_reset();
    @(negedge clock);
    chk("midreset_active", 32'(active), 32'd0);
    chk("midreset_base", base, 32'd0);
    chk("midreset_mask", 32'(ready_mask), 32'd0);
    chk("midreset_idle", 32'(idle), 32'd1);
    tick();
    repeat (3) tick();

    // stop freezes the slice; admit still lands
    set_q(32'd3);
    do_admit(3'd6);
    exp_disp(3'd6, 8'h40);
    pulse_yield();
    wait_pulse(1'b1, 2, "stop_dispatch_latency");
    pulse_retire();
    stop = 1'b1;
    retire = 1'b1;
    admit = 1'b1;
    admit_id = 3'd7;
    tick();
    admit = 1'b0;
    repeat (4) tick();
    @(negedge clock);
    chk("stop_active_held", 32'(active), 32'd6);
    chk("stop_base_held", base, 32'd1200);
    chk("stop_admit_mask", 32'(ready_mask), 32'hC0);
    tick();
    stop = 1'b0;
    retire = 1'b0;
    pulse_retire();
    exp_pre(8'hC0);
    pulse_retire();
    wait_pulse(1'b0, 1, "stop_expiry_latency");
    repeat (2) tick();

    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/process_scheduler.md
# process_scheduler

Round-robin time-slice scheduler for the multiprogrammed core. It tracks which program slots are ready and counts retired instructions against a quantum. It preempts the running program on expiry or termination, returning control to the OS (slot 0), and picks the next program to dispatch when the OS yields. It drives the program selection and base-address offset that the program counter adds to branch targets.

## Interface
Parameters:
- NPROG, 8, number of program slots including OS slot 0
- PROG_SIZE, 200, instruction words per slot; base = slot * PROG_SIZE
- QW, 32, quantum/counter width

Ports:
- clock  in  1  system clock, all logic on posedge
- reset  in  1  synchronous, active-high reset
- stop  in  1  halt; freezes counter and FSM (admit/defquantum still accepted)
- defquantum  in  1  load quantum register from quantum_in
- quantum_in  in  QW  new quantum; 0 disables preemption
- admit  in  1  mark slot admit_id ready
- admit_id  in  $clog2(NPROG)  slot to admit; 0 ignored
- retire  in  1  running program completed one instruction
- endProgram  in  1  running program executed its halt
- yield  in  1  OS requests dispatch of next program
- active  out  $clog2(NPROG)  currently running slot
- base  out  32  active * PROG_SIZE
- preempt  out  1  one-cycle pulse: control returns to OS
- dispatch  out  1  one-cycle pulse: active/base hold new program
- ready_mask  out  NPROG  ready set; bit 0 always 0
- idle  out  1  no user program ready (ready_mask == 0)

## Operation
- FSM states: OS, SELECT, RUN.
- Reset values: state=OS, active=0, base=0, quantum=0, count=0, last=0, ready_mask=0, preempt=0, dispatch=0, idle=1.
- OS state: yield with ready_mask != 0 → SELECT; yield with empty mask → stay OS, no pulse.
- SELECT: picker scans slots last+1 … NPROG-1, then 1 … last, and takes the first ready one. It registers active, base, dispatch=1, count=0 and goes to RUN. The mask cannot become empty here because only endProgram clears bits.
- RUN, no stop: retire increments count (saturating at 2^QW-1).
- RUN, endProgram: clear ready bit of active, last=active, active=0, base=0, preempt=1 → OS. endProgram has priority over quantum expiry.
- RUN, quantum expiry: if quantum != 0 and retire arrives while count == quantum-1, then last=active, active=0, base=0, preempt=1 → OS. The slot stays ready.
- Quantum register updates on the edge after defquantum. The new value is used for comparisons from then on, including mid-slice. If a slice's count already exceeds the new quantum, it expires on the next retire.
- admit and endProgram for the same slot in the same cycle: admit wins, so the bit stays set.
- stop high: FSM, count and pulses frozen (pulses forced 0). ready_mask and quantum still update.
- reset mid-slice: everything returns to reset values next edge, with no preempt pulse.

## Timing
- preempt and dispatch are registered single-cycle pulses, never high together.
- yield high in cycle n → dispatch high in cycle n+2, with active/base valid from that cycle.
- Expiry: the quantum-th retire in cycle n → preempt high and active=0 in cycle n+1.
- endProgram in cycle n → preempt in cycle n+1, and the ready bit is clear in cycle n+1.
- admit in cycle n → ready_mask bit set and idle updated in cycle n+1.

## Configuration
- SCHED_RR_EN defined: round-robin search starting at last+1, as above.
- SCHED_RR_EN undefined: fixed priority, lowest-numbered ready slot ≥1 wins. The last register is not built.

## Structure
- Package sched_pkg: state enum (S_OS, S_SELECT, S_RUN), PROG_SIZE default, slot-id width localparam.
- Sub-module rr_picker: combinational. Takes ready_mask and start index; returns found flag and slot id. Its search mode is selected by SCHED_RR_EN.

## Test plan
- Reset, then yield with no admit → no dispatch, idle=1, active=0 over 10 cycles.
- Quantum=3, admit 2 and 5, yield → dispatch active=2, base=400. Third retire → preempt, active=0. Yield → active=5, base=1000.
- Quantum=0, program 3 runs 1000 retires → no preempt. endProgram → preempt, ready_mask bit 3 clear, idle=1.
- Slots 1, 2, 3 ready, quantum=1, repeated yield/retire → dispatch order 1, 2, 3, 1 with SCHED_RR_EN; order 1, 1, 1 without.
- Same-cycle admit_id=4 and endProgram while running slot 4 → bit 4 still set after preempt.
- stop high for 5 cycles mid-slice with retire pulsing → count unchanged, no preempt. After release, expiry lands at the original quantum count.
